// File: rtl/ecp5pll_phase_ctrl.sv
// ECP5 PLL dynamic phase-shift sequencer: turns signed per-channel step
// requests into timed phasesel/phasedir/phasestep pulses and tracks phase.
module ecp5pll_phase_ctrl #(
    parameter int CHANNELS  = 4,
    parameter int MOD0      = 16,
    parameter int MOD1      = 16,
    parameter int MOD2      = 16,
    parameter int MOD3      = 16,
    parameter int DW        = 11,
    parameter int SETUP_CYC = 2,
    parameter int STEP_CYC  = 4,
    parameter int GAP_CYC   = 4,
    parameter int LOCK_TMO  = 4096
) (
    input  logic            clk_i,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_chan,
    input  logic [DW-1:0]   req_delta,
    input  logic            req_reload,
    input  logic            pll_locked,
    output logic [1:0]      pll_phasesel,
    output logic            pll_phasedir,
    output logic            pll_phasestep,
    output logic            pll_phaseloadreg,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [4*DW-1:0] phase_o
);

    localparam int T01  = (SETUP_CYC > STEP_CYC) ? SETUP_CYC : STEP_CYC;
    localparam int T02  = (T01 > GAP_CYC) ? T01 : GAP_CYC;
    localparam int TMAX = (T02 > LOCK_TMO) ? T02 : LOCK_TMO;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, STEP_HI, STEP_LO, LOAD, LOCKWAIT
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [DW:0]          cnt_q, cnt_d;
    logic                 rel_q, rel_d;
    logic [1:0]           sel_q, sel_d;
    logic                 dir_q, dir_d;
    logic                 step_q, step_d;
    logic                 load_q, load_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [3:0][DW-1:0]   phase_q, phase_d;

    logic [DW:0]          dext;
    logic [DW:0]          mag;
    logic [DW-1:0]        cur;
    logic [DW-1:0]        last;

    function automatic logic [DW-1:0] mod_last(input logic [1:0] c);
        logic [DW-1:0] m;
        unique case (c)
            2'd0: m = DW'(MOD0 - 1);
            2'd1: m = DW'(MOD1 - 1);
            2'd2: m = DW'(MOD2 - 1);
            2'd3: m = DW'(MOD3 - 1);
        endcase
        return m;
    endfunction

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        // magnitude in DW+1 bits so the most negative delta is representable
        dext    = {req_delta[DW-1], req_delta};
        mag     = dext[DW] ? (~dext + 1'b1) : dext;
        cur     = phase_q[sel_q];
        last    = mod_last(sel_q);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (int'(req_chan) >= CHANNELS) begin
                        err_d = 1'b1;
                    end else if (req_reload) begin
                        sel_d   = req_chan;
                        rel_d   = 1'b1;
                        tmr_d   = '0;
                        state_d = SETUP;
                    end else if (mag == '0) begin
                        done_d = 1'b1;
                    end else begin
                        sel_d   = req_chan;
                        dir_d   = req_delta[DW-1];
                        cnt_d   = mag;
                        rel_d   = 1'b0;
                        tmr_d   = '0;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                if (tmr_q == TW'(SETUP_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = rel_q ? LOAD : STEP_HI;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            STEP_HI: begin
                if (tmr_q == TW'(STEP_CYC - 1)) begin
                    tmr_d = '0;
                    cnt_d = cnt_q - (DW+1)'(1);
                    if (dir_q)
                        phase_d[sel_q] = (cur == '0) ? last : cur - DW'(1);
                    else
                        phase_d[sel_q] = (cur == last) ? '0 : cur + DW'(1);
                    state_d = STEP_LO;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            STEP_LO: begin
                if (tmr_q == TW'(GAP_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = (cnt_q != '0) ? SETUP : LOCKWAIT;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            LOAD: begin
                if (tmr_q == TW'(STEP_CYC - 1)) begin
                    tmr_d          = '0;
                    rel_d          = 1'b0;
                    phase_d[sel_q] = '0;
                    state_d        = LOCKWAIT;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            LOCKWAIT: begin
                if (pll_locked) begin
                    done_d  = 1'b1;
                    tmr_d   = '0;
                    state_d = IDLE;
                end else if (tmr_q == TW'(LOCK_TMO - 1)) begin
                    err_d   = 1'b1;
                    tmr_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // strobes are registered copies of the next state, so no decode glitches
        step_d = (state_d == STEP_HI);
        load_d = (state_d == LOAD);
    end

    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
            rel_q   <= 1'b0;
            sel_q   <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            load_q  <= load_d;
            done_q  <= done_d;
            err_q   <= err_d;
            phase_q <= phase_d;
        end
    end

    assign req_ready        = (state_q == IDLE);
    assign busy             = (state_q != IDLE);
    assign pll_phasesel     = sel_q;
    assign pll_phasedir     = dir_q;
    assign pll_phasestep    = step_q;
    assign pll_phaseloadreg = load_q;
    assign done             = done_q;
    assign err              = err_q;
    assign phase_o          = phase_q;

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Randomized bench for ecp5pll_phase_ctrl with a modular-arithmetic phase
// model and a pulse monitor for strobe width, gap and sel/dir stability.
module tb_ecp5pll_phase_ctrl;

    localparam int CH    = 3;
    localparam int DW    = 11;
    localparam int SETUP = 2;
    localparam int STEP  = 4;
    localparam int GAP   = 4;
    localparam int TMO   = 4096;
    localparam int PER   = SETUP + STEP + GAP;

    logic            clk = 1'b0;
    logic            resetn;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_chan;
    logic [DW-1:0]   req_delta;
    logic            req_reload;
    logic            pll_locked;
    logic [1:0]      pll_phasesel;
    logic            pll_phasedir;
    logic            pll_phasestep;
    logic            pll_phaseloadreg;
    logic            busy;
    logic            done;
    logic            err;
    logic [4*DW-1:0] phase_o;

    int n_vec = 0;
    int n_mis = 0;
    int phm[4];

    always #5 clk = ~clk;

    ecp5pll_phase_ctrl #(
        .CHANNELS(CH), .MOD0(16), .MOD1(24), .MOD2(16), .MOD3(16),
        .DW(DW), .SETUP_CYC(SETUP), .STEP_CYC(STEP), .GAP_CYC(GAP),
        .LOCK_TMO(TMO)
    ) dut (
        .clk_i(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_chan(req_chan), .req_delta(req_delta),
        .req_reload(req_reload), .pll_locked(pll_locked),
        .pll_phasesel(pll_phasesel), .pll_phasedir(pll_phasedir),
        .pll_phasestep(pll_phasestep),
        .pll_phaseloadreg(pll_phaseloadreg),
        .busy(busy), .done(done), .err(err), .phase_o(phase_o)
    );

    function automatic int mod_of(input int c);
        return (c == 1) ? 24 : 16;
    endfunction

    function automatic int fld(input int c);
        return int'(phase_o[c*DW +: DW]);
    endfunction

    function automatic void model_step(input int c, input int d);
        phm[c] = ((phm[c] + d) % mod_of(c) + mod_of(c)) % mod_of(c);
    endfunction

    // pulse monitor (sole writer of these counters)
    int  step_rise = 0, step_badw = 0, step_badgap = 0;
    int  load_rise = 0, load_badw = 0, glitch = 0;
    int  hilen = 0, lowlen = 0, ldlen = 0;
    bit  inrun = 0, pst = 0, pld = 0;
    logic [1:0] psel = 2'd0, sel_seen = 2'd0;
    logic pdir = 1'b0, dir_seen = 1'b0;
    int  fall_ph[$];

    initial begin
        forever begin
            @(negedge clk);
            if (pll_phasestep) begin
                if (!pst) begin
                    step_rise++;
                    if (inrun && lowlen != SETUP + GAP) step_badgap++;
                    hilen = 1;
                    sel_seen = pll_phasesel;
                    dir_seen = pll_phasedir;
                end else begin
                    hilen++;
                    if (pll_phasesel !== psel || pll_phasedir !== pdir) glitch++;
                end
            end else if (pst) begin
                if (hilen != STEP) step_badw++;
                fall_ph.push_back(fld(int'(sel_seen)));
                inrun = 1;
                lowlen = 1;
            end else begin
                lowlen++;
            end
            if (!busy) inrun = 0;
            if (pll_phaseloadreg) begin
                if (!pld) begin
                    load_rise++;
                    ldlen = 1;
                end else begin
                    ldlen++;
                    if (pll_phasesel !== psel || pll_phasedir !== pdir) glitch++;
                end
            end else if (pld) begin
                if (ldlen != STEP) load_badw++;
            end
            if (pll_phasestep && pll_phaseloadreg) glitch++;
            pst  = pll_phasestep;
            pld  = pll_phaseloadreg;
            psel = pll_phasesel;
            pdir = pll_phasedir;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver: one transfer, then watch until done/err (called at a negedge)
    task automatic issue(input int ch, input int d, input bit rl, input int budget,
                         output int nbusy, output int ndone, output int nerr,
                         output int lat, output int nrdylo, output int after,
                         output bit tmo);
        nbusy = 0; ndone = 0; nerr = 0; lat = 0; nrdylo = 0; after = 0; tmo = 1;
        req_valid  = 1'b1;
        req_chan   = ch[1:0];
        req_delta  = DW'(d);
        req_reload = rl;
        @(negedge clk);
        req_valid  = 1'b0;
        req_chan   = 2'($urandom);
        req_delta  = DW'($urandom);
        req_reload = 1'($urandom);
        for (int k = 1; k <= budget; k++) begin
            if (busy) nbusy++;
            if (!req_ready) nrdylo++;
            if (done || err) begin
                ndone = int'(done);
                nerr  = int'(err);
                lat   = k;
                tmo   = 0;
                break;
            end
            @(negedge clk);
        end
        if (!tmo) begin
            @(negedge clk);
            after = int'(done) + int'(err) + int'(busy);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_valid = 1'b0; req_chan = 2'd0;
        req_delta = '0; req_reload = 1'b0; pll_locked = 1'b1;
        for (int c = 0; c < 4; c++) phm[c] = 0;
        #3;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_mis++; $display("FAIL reset_ready got %b want 1", req_ready);
        end
        n_vec++;
        if ({busy, done, err, pll_phasestep, pll_phaseloadreg,
             pll_phasedir, pll_phasesel} !== 8'd0) begin
            n_mis++;
            $display("FAIL reset_outs got %b%b%b%b%b%b%b want 0", busy, done, err,
                     pll_phasestep, pll_phaseloadreg, pll_phasedir, pll_phasesel);
        end
        n_vec++;
        if (phase_o !== '0) begin
            n_mis++; $display("FAIL reset_phase got %h want 0", phase_o);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_steps();
        int nb, nd, ne, lat, nr, af; bit to;
        int sr = step_rise, bw = step_badw, bg = step_badgap;
        int lr = load_rise, gl = glitch;
        issue(1, 3, 1'b0, 200, nb, nd, ne, lat, nr, af, to);
        model_step(1, 3);
        n_vec++;
        if (to || nd != 1 || ne != 0) begin
            n_mis++; $display("FAIL steps_done got done=%0d err=%0d tmo=%0d want 1 0 0", nd, ne, to);
        end
        n_vec++;
        if (nb != 3*PER + 1) begin
            n_mis++; $display("FAIL steps_busy got %0d want %0d", nb, 3*PER + 1);
        end
        n_vec++;
        if (step_rise - sr != 3) begin
            n_mis++; $display("FAIL steps_count got %0d want 3", step_rise - sr);
        end
        n_vec++;
        if (step_badw != bw || step_badgap != bg || glitch != gl) begin
            n_mis++;
            $display("FAIL steps_shape got badw=%0d badgap=%0d glitch=%0d want 0 0 0",
                     step_badw - bw, step_badgap - bg, glitch - gl);
        end
        n_vec++;
        if (sel_seen !== 2'd1 || dir_seen !== 1'b0 || pll_phasesel !== 2'd1) begin
            n_mis++;
            $display("FAIL steps_seldir got sel=%0d dir=%0d idle_sel=%0d want 1 0 1",
                     sel_seen, dir_seen, pll_phasesel);
        end
        n_vec++;
        if (load_rise != lr || af != 0) begin
            n_mis++; $display("FAIL steps_misc got loads=%0d after=%0d want 0 0", load_rise - lr, af);
        end
        n_vec++;
        if (fld(1) != phm[1]) begin
            n_mis++; $display("FAIL steps_phase got %0d want %0d", fld(1), phm[1]);
        end
    endtask

    task automatic test_retard();
        int nb, nd, ne, lat, nr, af; bit to;
        int fi = fall_ph.size();
        issue(2, -2, 1'b0, 200, nb, nd, ne, lat, nr, af, to);
        model_step(2, -2);
        n_vec++;
        if (to || nd != 1 || dir_seen !== 1'b1) begin
            n_mis++; $display("FAIL retard_done got done=%0d dir=%0d want 1 1", nd, dir_seen);
        end
        n_vec++;
        if (fall_ph.size() != fi + 2) begin
            n_mis++; $display("FAIL retard_nsteps got %0d want 2", fall_ph.size() - fi);
        end else if (fall_ph[fi] != 15 || fall_ph[fi+1] != 14) begin
            n_mis++;
            $display("FAIL retard_seq got %0d,%0d want 15,14", fall_ph[fi], fall_ph[fi+1]);
        end
        n_vec++;
        if (fld(2) != phm[2]) begin
            n_mis++; $display("FAIL retard_phase got %0d want %0d", fld(2), phm[2]);
        end
    endtask

    task automatic test_bad_chan();
        int nb, nd, ne, lat, nr, af; bit to;
        int sr = step_rise;
        issue(3, $urandom_range(1, 20), 1'b0, 20, nb, nd, ne, lat, nr, af, to);
        n_vec++;
        if (to || ne != 1 || nd != 0 || lat != 1) begin
            n_mis++; $display("FAIL badch_err got err=%0d done=%0d lat=%0d want 1 0 1", ne, nd, lat);
        end
        n_vec++;
        if (nr != 0 || nb != 0 || step_rise != sr || af != 0) begin
            n_mis++;
            $display("FAIL badch_quiet got rdylo=%0d busy=%0d steps=%0d after=%0d want 0",
                     nr, nb, step_rise - sr, af);
        end
    endtask

    task automatic test_lock_timeout();
        int nb, nd, ne, lat, nr, af; bit to;
        pll_locked = 1'b0;
        issue(0, 1, 1'b0, TMO + 200, nb, nd, ne, lat, nr, af, to);
        pll_locked = 1'b1;
        model_step(0, 1);
        n_vec++;
        if (to || ne != 1 || nd != 0) begin
            n_mis++; $display("FAIL tmo_err got err=%0d done=%0d tmo=%0d want 1 0 0", ne, nd, to);
        end
        n_vec++;
        if (nb != PER + TMO) begin
            n_mis++; $display("FAIL tmo_busy got %0d want %0d", nb, PER + TMO);
        end
        n_vec++;
        if (fld(0) != phm[0] || af != 0) begin
            n_mis++; $display("FAIL tmo_phase got %0d after=%0d want %0d 0", fld(0), af, phm[0]);
        end
    endtask

    task automatic test_reload();
        int nb, nd, ne, lat, nr, af; bit to;
        int sr, lr, lw;
        issue(0, 5 - phm[0], 1'b0, 400, nb, nd, ne, lat, nr, af, to);
        model_step(0, 5 - phm[0]);
        n_vec++;
        if (fld(0) != 5) begin
            n_mis++; $display("FAIL reload_pre got %0d want 5", fld(0));
        end
        sr = step_rise; lr = load_rise; lw = load_badw;
        issue(0, int'($urandom_range(0, 30)) - 15, 1'b1, 100, nb, nd, ne, lat, nr, af, to);
        phm[0] = 0;
        n_vec++;
        if (to || nd != 1 || nb != SETUP + STEP + 1) begin
            n_mis++;
            $display("FAIL reload_done got done=%0d busy=%0d want 1 %0d", nd, nb, SETUP + STEP + 1);
        end
        n_vec++;
        if (load_rise - lr != 1 || load_badw != lw || step_rise != sr) begin
            n_mis++;
            $display("FAIL reload_strobes got loads=%0d badw=%0d steps=%0d want 1 0 0",
                     load_rise - lr, load_badw - lw, step_rise - sr);
        end
        n_vec++;
        if (fld(0) != 0) begin
            n_mis++; $display("FAIL reload_phase got %0d want 0", fld(0));
        end
        sr = step_rise; lr = load_rise;
        issue(0, 0, 1'b0, 20, nb, nd, ne, lat, nr, af, to);
        n_vec++;
        if (to || nd != 1 || lat != 1 || nb != 0 || step_rise != sr || load_rise != lr) begin
            n_mis++;
            $display("FAIL zero_delta got done=%0d lat=%0d busy=%0d strobes=%0d want 1 1 0 0",
                     nd, lat, nb, step_rise - sr + load_rise - lr);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        req_valid = 1'b1; req_chan = 2'd2; req_delta = DW'(5); req_reload = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (pll_phasestep) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        n_vec++;
        if (!seen) begin
            n_mis++; $display("FAIL rstmid_step got no phasestep want one within 60 cycles");
        end
        #2;
        resetn = 1'b0;
        #1;
        n_vec++;
        if (pll_phasestep !== 1'b0 || busy !== 1'b0 || pll_phaseloadreg !== 1'b0) begin
            n_mis++;
            $display("FAIL rstmid_drop got step=%b busy=%b load=%b want 0 0 0",
                     pll_phasestep, busy, pll_phaseloadreg);
        end
        for (int c = 0; c < 4; c++) phm[c] = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_vec++;
        if (phase_o !== '0 || req_ready !== 1'b1) begin
            n_mis++; $display("FAIL rstmid_after got phase=%h ready=%b want 0 1", phase_o, req_ready);
        end
    endtask

    task automatic test_random();
        int nb, nd, ne, lat, nr, af; bit to;
        int ch, d, n, sr, lr, bw, bg, gl;
        bit rl;
        for (int it = 0; it < 25; it++) begin
            ch = $urandom_range(0, CH - 1);
            rl = ($urandom_range(0, 7) == 0);
            d  = int'($urandom_range(0, 80)) - 40;
            n  = (d < 0) ? -d : d;
            sr = step_rise; lr = load_rise; bw = step_badw; bg = step_badgap; gl = glitch;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(ch, d, rl, n*PER + 50, nb, nd, ne, lat, nr, af, to);
            if (rl) phm[ch] = 0;
            else model_step(ch, d);
            n_vec++;
            if (to || nd != 1 || ne != 0 || af != 0) begin
                n_mis++;
                $display("FAIL rnd%0d_done got done=%0d err=%0d tmo=%0d after=%0d want 1 0 0 0",
                         it, nd, ne, to, af);
            end
            n_vec++;
            if (rl) begin
                if (nb != SETUP + STEP + 1 || load_rise - lr != 1 || step_rise != sr) begin
                    n_mis++;
                    $display("FAIL rnd%0d_reload got busy=%0d loads=%0d steps=%0d", it,
                             nb, load_rise - lr, step_rise - sr);
                end
            end else if (n == 0) begin
                if (nb != 0 || lat != 1 || step_rise != sr || load_rise != lr) begin
                    n_mis++; $display("FAIL rnd%0d_zero got busy=%0d lat=%0d want 0 1", it, nb, lat);
                end
            end else begin
                if (nb != n*PER + 1 || step_rise - sr != n || load_rise != lr ||
                    sel_seen !== ch[1:0] || dir_seen !== (d < 0)) begin
                    n_mis++;
                    $display("FAIL rnd%0d_steps got busy=%0d steps=%0d sel=%0d dir=%0d want %0d %0d %0d %0d",
                             it, nb, step_rise - sr, sel_seen, dir_seen, n*PER + 1, n, ch, d < 0);
                end
            end
            n_vec++;
            if (step_badw != bw || step_badgap != bg || glitch != gl) begin
                n_mis++; $display("FAIL rnd%0d_shape got pulse shape or sel/dir change", it);
            end
            for (int c = 0; c < CH; c++) begin
                n_vec++;
                if (fld(c) != phm[c]) begin
                    n_mis++; $display("FAIL rnd%0d_phase%0d got %0d want %0d", it, c, fld(c), phm[c]);
                end
            end
        end
    endtask

    task automatic test_extremes();
        int nb, nd, ne, lat, nr, af; bit to;
        int sr = step_rise;
        issue(1, -1024, 1'b0, 1024*PER + 50, nb, nd, ne, lat, nr, af, to);
        model_step(1, -1024);
        n_vec++;
        if (to || nd != 1 || step_rise - sr != 1024 || dir_seen !== 1'b1) begin
            n_mis++;
            $display("FAIL mostneg got done=%0d steps=%0d dir=%0d want 1 1024 1",
                     nd, step_rise - sr, dir_seen);
        end
        n_vec++;
        if (fld(1) != phm[1]) begin
            n_mis++; $display("FAIL mostneg_phase got %0d want %0d", fld(1), phm[1]);
        end
        issue(1, 50, 1'b0, 50*PER + 50, nb, nd, ne, lat, nr, af, to);
        model_step(1, 50);
        n_vec++;
        if (to || nd != 1 || fld(1) != phm[1]) begin
            n_mis++; $display("FAIL wrap_fwd got done=%0d phase=%0d want 1 %0d", nd, fld(1), phm[1]);
        end
    endtask

    initial begin
        test_reset();
        test_steps();
        test_retard();
        test_bad_chan();
        test_lock_timeout();
        test_reload();
        test_reset_mid();
        test_random();
        test_extremes();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
